hack_rom_loader: RTL and testbench

- Receive-side program uploader for the Hack computer.
- Accepts a byte stream with a valid/ready handshake, packs big-endian byte pairs into 16-bit Hack instruction words, and writes them to instruction ROM at consecutive addresses from 0.
- Checks a trailing 16-bit checksum and holds the CPU in reset while loading.
- Sits between the host byte link (UART RX or bench driver) and the ROM write port.

---
 rtl/hack_pkg.sv | 16 +
 rtl/hack_word_packer.sv | 27 ++
 rtl/hack_rom_loader.sv | 114 +++++++++++
 tb/tb_hack_rom_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack ROM loader.
package hack_pkg;
    localparam int WORD_W         = 16;
    localparam int BYTE_W         = 8;
    localparam int DEFAULT_ADDR_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CSUM_HI,
        ST_CSUM_LO,
        ST_DONE
    } load_state_e;
endpackage

// File: rtl/hack_word_packer.sv
// Big-endian byte-pair assembler: keeps the high byte, presents {high, current byte}.
module hack_word_packer
    import hack_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              accept_i,
    input  logic              hi_phase_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              byte_valid_i,
    output logic              fire_o,
    output logic [WORD_W-1:0] word_o
);
    logic [BYTE_W-1:0] hi_q;

    // A transfer happens on any edge where the byte is valid and the loader is ready.
    assign fire_o = accept_i && byte_valid_i;
    assign word_o = {hi_q, byte_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
        end else if (fire_o && hi_phase_i) begin
            hi_q <= byte_i;
        end
    end
endmodule

// File: rtl/hack_rom_loader.sv
// Byte-stream program uploader: packs words into instruction ROM, verifies a trailing checksum.
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [WORD_W-1:0] rom_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cpu_rst_o
);
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    load_state_e       state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    logic [WORD_W-1:0] csum;
    logic              fire;
    logic              hi_phase;
    logic [WORD_W-1:0] word;

    assign hi_phase  = (state == ST_HI) || (state == ST_CSUM_HI);
    assign cpu_rst_o = busy_o;

    hack_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .accept_i     (byte_ready_o),
        .hi_phase_i   (hi_phase),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .fire_o       (fire),
        .word_o       (word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            addr         <= '0;
            len          <= '0;
            csum         <= '0;
            byte_ready_o <= 1'b0;
            rom_we_o     <= 1'b0;
            rom_addr_o   <= '0;
            rom_data_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rom_we_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        len          <= len_i;
                        addr         <= '0;
                        csum         <= '0;
                        done_o       <= 1'b0;
                        err_o        <= 1'b0;
                        busy_o       <= 1'b1;
                        byte_ready_o <= 1'b1;
                        state        <= (len_i != '0) ? ST_HI : ST_CSUM_HI;
                    end
                end
                ST_HI: begin
                    if (fire) state <= ST_LO;
                end
                ST_LO: begin
                    // The write strobe is registered here so it is high for the whole WRITE cycle.
                    if (fire) begin
                        byte_ready_o <= 1'b0;
                        rom_we_o     <= 1'b1;
                        rom_addr_o   <= addr;
                        rom_data_o   <= word;
                        state        <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    csum         <= csum + rom_data_o;
                    byte_ready_o <= 1'b1;
                    if ({1'b0, addr} == len - LEN_ONE) begin
                        state <= ST_CSUM_HI;
                    end else begin
                        addr  <= addr + ADDR_ONE;
                        state <= ST_HI;
                    end
                end
                ST_CSUM_HI: begin
                    if (fire) state <= ST_CSUM_LO;
                end
                ST_CSUM_LO: begin
                    if (fire) begin
                        err_o        <= (word != csum);
                        done_o       <= 1'b1;
                        busy_o       <= 1'b0;
                        byte_ready_o <= 1'b0;
                        state        <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: a default-width instance and an ADDR_W=4 instance.
module tb_hack_rom_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [7:0]  byte_d;
    logic        valid_d;

    logic        start_a, start_b;
    logic [15:0] len_a;
    logic [4:0]  len_b;

    logic        ready_a, we_a, busy_a, done_a, err_a, cpu_rst_a;
    logic [14:0] addr_a;
    logic [15:0] data_a;
    logic        ready_b, we_b, busy_b, done_b, err_b, cpu_rst_b;
    logic [3:0]  addr_b;
    logic [15:0] data_b;

    logic        valid_a, valid_b;
    logic        cur_ready, cur_busy, cur_done, cur_err, cur_cpu_rst;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_count = 0;
    logic [31:0] exp_q[$];
    logic [15:0] tx_words[$];

    assign valid_a     = valid_d && !sel;
    assign valid_b     = valid_d && sel;
    assign cur_ready   = sel ? ready_b : ready_a;
    assign cur_busy    = sel ? busy_b : busy_a;
    assign cur_done    = sel ? done_b : done_a;
    assign cur_err     = sel ? err_b : err_a;
    assign cur_cpu_rst = sel ? cpu_rst_b : cpu_rst_a;

    hack_rom_loader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .len_i(len_a),
        .byte_i(byte_d), .byte_valid_i(valid_a), .byte_ready_o(ready_a),
        .rom_we_o(we_a), .rom_addr_o(addr_a), .rom_data_o(data_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .cpu_rst_o(cpu_rst_a)
    );

    hack_rom_loader #(.ADDR_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .len_i(len_b),
        .byte_i(byte_d), .byte_valid_i(valid_b), .byte_ready_o(ready_b),
        .rom_we_o(we_b), .rom_addr_o(addr_b), .rom_data_o(data_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .cpu_rst_o(cpu_rst_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every ROM write must match the head of the expected queue.
    always @(negedge clk) begin
        logic [31:0] got;
        if (we_a || we_b) begin
            wr_count++;
            got = we_a ? {1'b0, addr_a, data_a} : {12'b0, addr_b, data_b};
            check("rom_write_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rom_write", got, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int cnt;
        if (gaps) begin
            valid_d = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        byte_d  = b;
        valid_d = 1'b1;
        cnt     = 0;
        while (!cur_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) check("byte_accept_timeout", 32'(cur_ready), 32'd1);
        @(posedge clk);
        #1 valid_d = 1'b0;
    endtask

    task automatic run_load(input bit use_b, input int n, input logic [15:0] csum,
                            input bit gaps, input bit poke);
        int cnt;
        sel      = use_b;
        wr_count = 0;
        if (use_b) begin
            len_b   = 5'(n);
            start_b = 1'b1;
        end else begin
            len_a   = 16'(n);
            start_a = 1'b1;
        end
        @(posedge clk);
        #1 start_a = 1'b0;
        start_b = 1'b0;
        check("busy_after_start", 32'(cur_busy), 32'd1);
        check("cpu_rst_after_start", 32'(cur_cpu_rst), 32'd1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({16'(i), tx_words[i]});
            send_byte(tx_words[i][15:8], gaps);
            send_byte(tx_words[i][7:0], gaps);
            if (poke && i == 0) begin
                start_a = 1'b1;
                len_a   = 16'd0;
                @(posedge clk);
                #1 start_a = 1'b0;
            end
        end
        send_byte(csum[15:8], gaps);
        send_byte(csum[7:0], gaps);
        cnt = 0;
        while (!cur_done && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic check_end(input string tag, input logic exp_err, input int exp_writes);
        @(negedge clk);
        check({tag, "_done"}, 32'(cur_done), 32'd1);
        check({tag, "_err"}, 32'(cur_err), 32'(exp_err));
        check({tag, "_busy"}, 32'(cur_busy), 32'd0);
        check({tag, "_cpu_rst"}, 32'(cur_cpu_rst), 32'd0);
        check({tag, "_ready"}, 32'(cur_ready), 32'd0);
        check({tag, "_writes"}, 32'(wr_count), 32'(exp_writes));
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; byte_d = '0; valid_d = 1'b0;
        start_a = 1'b0; start_b = 1'b0; len_a = '0; len_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst_a), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 0x0007 + 0xEC10 = 0xEC17
        tx_words = '{16'h0007, 16'hEC10};
        run_load(1'b0, 2, 16'hEC17, 1'b0, 1'b0);
        check_end("len2_ok", 1'b0, 2);

        run_load(1'b0, 2, 16'h0000, 1'b0, 1'b0);
        check_end("len2_bad", 1'b1, 2);

        // 0x1234 + 0xABCD + 0x0F0F + 0xFFFF = 0x1CD0F -> 0xCD0F
        tx_words = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF};
        run_load(1'b0, 4, 16'hCD0F, 1'b1, 1'b0);
        check_end("len4_gaps", 1'b0, 4);

        run_load(1'b0, 0, 16'h0000, 1'b0, 1'b0);
        check_end("len0", 1'b0, 0);

        tx_words = '{16'h0001, 16'h0002, 16'h0003};
        run_load(1'b0, 3, 16'h0006, 1'b0, 1'b1);
        check_end("start_ignored", 1'b0, 3);

        // Reset while the first word of a len=3 load is being written.
        sel = 1'b0; wr_count = 0;
        len_a = 16'd3; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        exp_q.push_back({16'd0, 16'hAAAA});
        send_byte(8'hAA, 1'b0);
        send_byte(8'hAA, 1'b0);
        check("mid_in_write", 32'(we_a), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready", 32'(ready_a), 32'd0);
        check("mid_rst_we", 32'(we_a), 32'd0);
        check("mid_rst_addr", 32'(addr_a), 32'd0);
        check("mid_rst_data", 32'(data_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_cpu_rst", 32'(cpu_rst_a), 32'd0);
        rst = 1'b0;
        byte_d = 8'hFF; valid_d = 1'b1;
        repeat (5) @(posedge clk);
        #1 valid_d = 1'b0;
        check("mid_no_more_writes", 32'(wr_count), 32'd1);
        check("mid_idle_ready", 32'(ready_a), 32'd0);
        tx_words = '{16'h5A5A};
        run_load(1'b0, 1, 16'h5A5A, 1'b0, 1'b0);
        check_end("after_rst_len1", 1'b0, 1);

        // ADDR_W=4 full-depth load: 1+2+...+16 = 136 = 0x0088
        tx_words = {};
        for (int i = 1; i <= 16; i++) tx_words.push_back(16'(i));
        run_load(1'b1, 16, 16'h0088, 1'b0, 1'b0);
        check_end("full_depth", 1'b0, 16);
        check("full_depth_last_addr", 32'(addr_b), 32'd15);
        check("full_depth_last_data", 32'(data_b), 32'h0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
